// File: rtl/cpu_types_pkg.sv
// Shared CPU types, including the fetch-stage branch target buffer entry layout.
// The tag helper drops the index and byte-offset bits of a PC.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BP_IDX_W = 3;
    localparam int BP_TAG_W = 32 - BP_IDX_W - 2;

    typedef logic [1:0]          bp_ctr_t;
    typedef logic [BP_TAG_W-1:0] bp_tag_t;

    localparam bp_ctr_t BP_CTR_INIT  = 2'b01;
    localparam bp_ctr_t BP_ALLOC_CTR = 2'b10;

    typedef struct packed {
        logic    valid;
        bp_tag_t tag;
        word_t   target;
        bp_ctr_t ctr;
    } bp_entry_t;

    // Tag field is sized for BP_IDX_W; larger index widths zero-extend cleanly.
    function automatic bp_tag_t bp_tag(input word_t pc, input int idx_w);
        word_t shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[BP_TAG_W-1:0];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter, next-state only.
module sat_counter2 (
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; lookup is combinational, MEM-stage update is clocked.
// Optional resolved/mispredict statistics are built when BP_STATS_EN is defined.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int         IDX_W     = BP_IDX_W,
    parameter logic [1:0] CTR_INIT  = BP_CTR_INIT,
    parameter logic [1:0] ALLOC_CTR = BP_ALLOC_CTR
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      fetch_pc,
    output logic             predict,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_en,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_predict,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_mispred
);

    localparam int N_ENTRIES = 2 ** IDX_W;

    bp_entry_t entries [N_ENTRIES];
    bp_entry_t rd_entry;
    bp_entry_t wr_entry;
    logic      hit;
    logic      upd_hit;
    bp_ctr_t   ctr_next;

    assign pred_index  = fetch_pc[IDX_W+1:2];
    assign rd_entry    = entries[pred_index];
    assign hit         = rd_entry.valid && (rd_entry.tag == bp_tag(fetch_pc, IDX_W));
    assign predict     = hit && rd_entry.ctr[1];
    assign pred_target = predict ? rd_entry.target : '0;

    assign mispredict = upd_en && ((upd_predict != upd_taken) ||
                        (upd_taken && upd_predict && (upd_pred_target != upd_target)));

    // The pipe-carried index selects the entry; it is deliberately not re-derived from upd_pc.
    assign wr_entry = entries[upd_index];
    assign upd_hit  = wr_entry.valid && (wr_entry.tag == bp_tag(upd_pc, IDX_W));

    sat_counter2 u_ctr (
        .ctr      (wr_entry.ctr),
        .inc      (upd_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                entries[upd_index].ctr <= ctr_next;
                if (upd_taken) entries[upd_index].target <= upd_target;
            end else if (upd_taken) begin
                entries[upd_index] <= '{valid:  1'b1,
                                        tag:    bp_tag(upd_pc, IDX_W),
                                        target: upd_target,
                                        ctr:    ALLOC_CTR};
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] upd_cnt;
    logic [31:0] mis_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            upd_cnt <= '0;
            mis_cnt <= '0;
        end else begin
            if (upd_en && (upd_cnt != 32'hFFFF_FFFF)) upd_cnt <= upd_cnt + 32'd1;
            if (mispredict && (mis_cnt != 32'hFFFF_FFFF)) mis_cnt <= mis_cnt + 32'd1;
        end
    end

    assign stat_updates = upd_cnt;
    assign stat_mispred = mis_cnt;
`else
    assign stat_updates = '0;
    assign stat_mispred = '0;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direct-mapped branch target buffer with a 2-bit saturating counter per entry.
- Sits upstream of the IF/ID register. Supplies the predict bit, the predicted target and the table index, which travel down the pipe with the instruction (ifid_p, then idex_p, then exmem_p).
- Branches resolve in MEM, using the bra and zero fields of exmem_p. The MEM stage writes the outcome back into the table and this block reports mispredictions to the PC-select/flush logic.

Parameters:
- IDX_W, 3: index width; entry count = 2**IDX_W. Must match the index field width in idex_p/exmem_p.
- CTR_INIT, 2'b01: counter value loaded at reset (weakly not-taken).
- ALLOC_CTR, 2'b10: counter value loaded on allocation (weakly taken).

Ports:
- CLK  in  1  clock (rising edge).
- nRST  in  1  asynchronous, active-low reset.
- fetch_pc  in  32 (word_t)  PC of the instruction being fetched.
- predict  out  1  predict taken for fetch_pc.
- pred_target  out  32  predicted target; 0 when predict=0.
- pred_index  out  IDX_W  fetch_pc[IDX_W+1:2].
- upd_en  in  1  MEM stage holds a resolved conditional branch (bra != 2'b00) and is not stalled.
- upd_pc  in  32  PC of the resolving branch (exmem pc_plus4 - 4).
- upd_index  in  IDX_W  index carried through the pipe.
- upd_taken  in  1  actual outcome from bra/zero.
- upd_target  in  32  actual target (br_target).
- upd_predict  in  1  predict bit carried through the pipe.
- upd_pred_target  in  32  predicted target carried through the pipe.
- mispredict  out  1  combinational; pipeline must flush IF/ID/EX and redirect PC.
- stat_updates  out  32  resolved-branch count (BP_STATS_EN only, else 0).
- stat_mispred  out  32  mispredict count (BP_STATS_EN only, else 0).

Behaviour:
- Storage per entry: valid, tag = pc[31:IDX_W+2], target (32), ctr (2).
- Reset (asynchronous, nRST=0): all valid=0, ctr=CTR_INIT, target=0, stat counters=0. Outputs are combinational from the table, so predict=0 and pred_target=0 immediately.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == fetch_pc tag.
  - predict = hit && ctr[idx][1].
  - pred_target = predict ? target[idx] : 0.
- mispredict = upd_en && ((upd_predict != upd_taken) || (upd_taken && upd_predict && upd_pred_target != upd_target)). It is 0 whenever upd_en=0.
- Update on the rising edge when upd_en=1, at entry upd_index:
  - Tag match and valid:
    - ctr increments if taken, decrements if not; saturates at 2'b11 and 2'b00.
    - If taken, target <= upd_target.
  - Miss and taken: allocate/replace. valid<=1, tag<=upd_pc tag, target<=upd_target, ctr<=ALLOC_CTR.
  - Miss and not taken: no change.
- upd_en=0: table holds.
- Simultaneous lookup and update on the same index: lookup returns the pre-edge contents (no bypass). The new value is visible from the next cycle.
- upd_index is used as given; it is not recomputed from upd_pc.
- Reset mid-operation clears the table regardless of a pending update.
- Jumps and non-branches are never written; upd_en is gated by the caller.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_updates increments each cycle upd_en=1.
  - stat_mispred increments each cycle mispredict=1.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on reset.
- Undefined: the counter registers are not built and both outputs are tied to 0.

Decomposition:
- cpu_types_pkg additions:
  - constants BP_IDX_W=3, BP_CTR_INIT, BP_ALLOC_CTR.
  - typedef bp_ctr_t (logic [1:0]).
  - packed struct bp_entry_t {valid, tag, target, ctr}.
- One natural sub-module: sat_counter2 (2-bit saturating inc/dec, combinational next-state). It is instantiated per update path, not per entry.

Test Plan:
- Reset then lookup: fetch_pc=0x40 -> predict=0, pred_target=0, pred_index=3'd0.
- Allocate: upd_en=1, upd_pc=0x48, upd_index=2, upd_taken=1, upd_target=0x100, upd_predict=0 -> mispredict=1 that cycle. Next cycle fetch_pc=0x48 -> predict=1, pred_target=0x100.
- Saturation: three not-taken updates at 0x48 move ctr 10->01->00->00. predict=0 after the first; a following taken update gives ctr 01, predict still 0.
- Tag conflict: entry at 0x48, fetch_pc=0x68 (same index 2, different tag) -> predict=0. Taken update at 0x68 with target 0x200 replaces the entry; fetch_pc=0x48 then gives predict=0.
- Target mismatch: upd_predict=1, upd_taken=1, upd_pred_target=0x100, upd_target=0x180 -> mispredict=1, and the stored target becomes 0x180.
- Same-cycle read/write on index 2 returns old data; nRST asserted mid-stream clears the table and stat counters asynchronously. With BP_STATS_EN, after 5 updates and 2 mispredicts the outputs read 5/2.
